// File: rtl/video_out_formatter.sv
// rtl/video_out_formatter.sv - VGA output stage: H/V timing, VSYNC resync, sync/DE generation, pixel depth reduction
//
// Free-running horizontal/vertical counters are re-aligned to the rising edge of
// I_VSYNC after a programmable delay. Sync, data enable and pixel outputs are all
// registered, so every output reflects the counter state of the previous cycle.
//
// Optional feature macro: VOF_TEST_PATTERN_EN
//   defined   -> adds input I_TP_EN; when high, the pixel source is eight vertical colour bars
//   undefined -> pixel path is rounding/saturation only
//
// Ports
//   I_PCLK      in   1           pixel clock
//   I_RST       in   1           synchronous reset, active-high
//   I_VSYNC     in   1           input-side vertical sync, rising edge = frame start
//   I_TP_EN     in   1           test pattern enable (only with VOF_TEST_PATTERN_EN)
//   I_PIX_DATA  in   3*IN_BPC    input pixel, R in the MSBs, B in the LSBs
//   O_DE        out  1           data enable
//   O_HSYNC     out  1           horizontal sync, SYNC_POL level when active
//   O_VSYNC     out  1           vertical sync, SYNC_POL level when active
//   O_PIX_DATA  out  3*OUT_BPC   reduced pixel, zero outside DE
//   O_H_CNT     out  clog2(HTOT) horizontal position the outputs belong to
//   O_V_CNT     out  clog2(VTOT) vertical position the outputs belong to
//   O_LOCKED    out  1           last resync landed on the natural frame wrap

module video_out_formatter #(
    parameter int HACT     = 640,
    parameter int HFP      = 16,
    parameter int HSW      = 96,
    parameter int HBP      = 48,
    parameter int VACT     = 480,
    parameter int VFP      = 10,
    parameter int VSW      = 2,
    parameter int VBP      = 33,
    parameter int IN_BPC   = 8,
    parameter int OUT_BPC  = 4,
    parameter int VRST_DLY = 0,
    parameter int SYNC_POL = 0,
    localparam int HTOT    = HSW + HBP + HACT + HFP,
    localparam int VTOT    = VSW + VBP + VACT + VFP,
    localparam int HW      = $clog2(HTOT),
    localparam int VW      = $clog2(VTOT)
) (
    input  logic                   I_PCLK,
    input  logic                   I_RST,
    input  logic                   I_VSYNC,
`ifdef VOF_TEST_PATTERN_EN
    input  logic                   I_TP_EN,
`endif
    input  logic [3*IN_BPC-1:0]    I_PIX_DATA,
    output logic                   O_DE,
    output logic                   O_HSYNC,
    output logic                   O_VSYNC,
    output logic [3*OUT_BPC-1:0]   O_PIX_DATA,
    output logic [HW-1:0]          O_H_CNT,
    output logic [VW-1:0]          O_V_CNT,
    output logic                   O_LOCKED
);

    localparam logic [HW-1:0] HMAX     = HW'(HTOT - 1);
    localparam logic [VW-1:0] VMAX     = VW'(VTOT - 1);
    localparam logic [HW-1:0] H_SW     = HW'(HSW);
    localparam logic [VW-1:0] V_SW     = VW'(VSW);
    localparam logic [HW-1:0] H_DE_S   = HW'(HSW + HBP);
    localparam logic [HW-1:0] H_DE_E   = HW'(HSW + HBP + HACT);
    localparam logic [VW-1:0] V_DE_S   = VW'(VSW + VBP);
    localparam logic [VW-1:0] V_DE_E   = VW'(VSW + VBP + VACT);
    localparam int            SH       = IN_BPC - OUT_BPC;
    localparam logic          POL      = 1'(SYNC_POL);
    localparam logic          DLY_ZERO = (VRST_DLY == 0);
    // Loaded value counts down to zero; resync fires on the cycle it reads zero,
    // giving exactly VRST_DLY cycles between the edge and the firing cycle.
    localparam logic [9:0]    DLY_LD   = 10'((VRST_DLY == 0) ? 0 : VRST_DLY - 1);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          vsync_q;
    logic          dly_pend;
    logic [9:0]    dly_cnt;

    logic hs, vs, de;
    logic vs_edge, resync, at_wrap;
    logic [3*OUT_BPC-1:0] reduced;
    logic [3*OUT_BPC-1:0] pix_src;

    assign hs      = (h < H_SW);
    assign vs      = (v < V_SW);
    assign de      = (h >= H_DE_S) && (h < H_DE_E) && (v >= V_DE_S) && (v < V_DE_E);
    assign at_wrap = (h == HMAX) && (v == VMAX);

    // A new edge always wins over a pending countdown (latest edge restarts the delay).
    assign vs_edge = I_VSYNC & ~vsync_q;
    assign resync  = vs_edge ? DLY_ZERO : (dly_pend && (dly_cnt == 10'd0));

    // Per-channel rounding: add half an output LSB, shift, saturate on carry-out.
    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic [IN_BPC-1:0] c;
        assign c = I_PIX_DATA[ch*IN_BPC +: IN_BPC];
        if (SH == 0) begin : g_pass
            assign reduced[ch*OUT_BPC +: OUT_BPC] = c;
        end else begin : g_round
            logic [OUT_BPC:0] q;
            assign q = (OUT_BPC+1)'(({1'b0, c} + (IN_BPC+1)'(1 << (SH - 1))) >> SH);
            assign reduced[ch*OUT_BPC +: OUT_BPC] = q[OUT_BPC] ? {OUT_BPC{1'b1}} : q[OUT_BPC-1:0];
        end
    end

`ifdef VOF_TEST_PATTERN_EN
    localparam int BAR_W = (HACT / 8 > 0) ? HACT / 8 : 1;
    logic [31:0] bar_full;
    logic [2:0]  bar_idx;
    logic [2:0]  rgb;

    // Bar index is only meaningful inside DE; the clamp covers HACT not divisible by 8.
    always_comb begin
        bar_full = (32'(h) - 32'(HSW + HBP)) / 32'(BAR_W);
        bar_idx  = (bar_full > 32'd7) ? 3'd7 : bar_full[2:0];
        case (bar_idx)
            3'd0:    rgb = 3'b111;   // white
            3'd1:    rgb = 3'b110;   // yellow
            3'd2:    rgb = 3'b011;   // cyan
            3'd3:    rgb = 3'b010;   // green
            3'd4:    rgb = 3'b101;   // magenta
            3'd5:    rgb = 3'b100;   // red
            3'd6:    rgb = 3'b001;   // blue
            default: rgb = 3'b000;   // black
        endcase
        pix_src = I_TP_EN ? {{OUT_BPC{rgb[2]}}, {OUT_BPC{rgb[1]}}, {OUT_BPC{rgb[0]}}} : reduced;
    end
`else
    assign pix_src = reduced;
`endif

    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            h          <= '0;
            v          <= '0;
            vsync_q    <= 1'b0;
            dly_pend   <= 1'b0;
            dly_cnt    <= '0;
            O_DE       <= 1'b0;
            O_HSYNC    <= ~POL;
            O_VSYNC    <= ~POL;
            O_PIX_DATA <= '0;
            O_H_CNT    <= '0;
            O_V_CNT    <= '0;
            O_LOCKED   <= 1'b0;
        end else begin
            vsync_q <= I_VSYNC;

            if (vs_edge) begin
                dly_pend <= ~DLY_ZERO;
                dly_cnt  <= DLY_LD;
            end else if (dly_pend) begin
                if (dly_cnt == 10'd0)
                    dly_pend <= 1'b0;
                else
                    dly_cnt <= dly_cnt - 10'd1;
            end

            if (resync) begin
                h        <= '0;
                v        <= '0;
                O_LOCKED <= at_wrap;
            end else if (h == HMAX) begin
                h <= '0;
                v <= (v == VMAX) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end

            O_DE       <= de;
            O_HSYNC    <= hs ? POL : ~POL;
            O_VSYNC    <= vs ? POL : ~POL;
            O_PIX_DATA <= de ? pix_src : '0;
            O_H_CNT    <= h;
            O_V_CNT    <= v;
        end
    end

endmodule

// File: tb/tb_video_out_formatter.sv
// tb/tb_video_out_formatter.sv - directed self-checking bench for video_out_formatter
module tb_video_out_formatter;

    // Reduced timing keeps whole frames short: HTOT=25, VTOT=11, frame=275 cycles.
    localparam int HACT = 16, HFP = 2, HSW = 3, HBP = 4;
    localparam int VACT = 6,  VFP = 1, VSW = 2, VBP = 2;
    localparam int HTOT = HSW + HBP + HACT + HFP;
    localparam int VTOT = VSW + VBP + VACT + VFP;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);

    logic          I_PCLK = 1'b0;
    logic          I_RST = 1'b1;
    logic          I_VSYNC = 1'b0;
    logic          I_TP_EN = 1'b0;
    logic [23:0]   I_PIX_DATA = '0;
    logic          O_DE, O_HSYNC, O_VSYNC, O_LOCKED;
    logic [11:0]   O_PIX_DATA;
    logic [HW-1:0] O_H_CNT;
    logic [VW-1:0] O_V_CNT;

    int checks = 0;
    int failures = 0;

    video_out_formatter #(
        .HACT(HACT), .HFP(HFP), .HSW(HSW), .HBP(HBP),
        .VACT(VACT), .VFP(VFP), .VSW(VSW), .VBP(VBP),
        .IN_BPC(8), .OUT_BPC(4), .VRST_DLY(5), .SYNC_POL(0)
    ) dut (
        .I_PCLK    (I_PCLK),
        .I_RST     (I_RST),
        .I_VSYNC   (I_VSYNC),
`ifdef VOF_TEST_PATTERN_EN
        .I_TP_EN   (I_TP_EN),
`endif
        .I_PIX_DATA(I_PIX_DATA),
        .O_DE      (O_DE),
        .O_HSYNC   (O_HSYNC),
        .O_VSYNC   (O_VSYNC),
        .O_PIX_DATA(O_PIX_DATA),
        .O_H_CNT   (O_H_CNT),
        .O_V_CNT   (O_V_CNT),
        .O_LOCKED  (O_LOCKED)
    );

    always #5 I_PCLK = ~I_PCLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_PCLK);
        #1;
    endtask

    // Wait until the outputs report position (hh,vv); the internal counter is then one ahead.
    task automatic wait_hv(input string tag, input int hh, input int vv);
        logic found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (int'(O_H_CNT) == hh && int'(O_V_CNT) == vv) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    logic [23:0] rin  [4] = '{24'h07087F, 24'hF8FF00, 24'h1788F7, 24'h000000};
    logic [11:0] rexp [4] = '{12'h018,    12'hFF0,    12'h19F,    12'h000};

    initial begin
        int err_h, err_v, err_hs, err_vs, err_de, err_pix;
        int de_total, hs_low, vs_low, first_de_h, first_de_v, last_de_v;

        // Reset
        I_RST = 1'b1;
        tick(); tick(); tick();
        check("rst_de",     32'(O_DE), 0);
        check("rst_hsync",  32'(O_HSYNC), 1);
        check("rst_vsync",  32'(O_VSYNC), 1);
        check("rst_pix",    32'(O_PIX_DATA), 0);
        check("rst_locked", 32'(O_LOCKED), 0);
        check("rst_hcnt",   32'(O_H_CNT), 0);
        check("rst_vcnt",   32'(O_V_CNT), 0);

        // One full free-running frame; saturating white pixel in
        I_RST = 1'b0;
        I_PIX_DATA = 24'hFFFFFF;
        err_h = 0; err_v = 0; err_hs = 0; err_vs = 0; err_de = 0; err_pix = 0;
        de_total = 0; hs_low = 0; vs_low = 0;
        first_de_h = -1; first_de_v = -1; last_de_v = -1;
        for (int k = 0; k < HTOT * VTOT; k++) begin
            int  eh, ev;
            logic de_e;
            tick();
            eh   = k % HTOT;
            ev   = k / HTOT;
            de_e = (eh >= 7) && (eh < 23) && (ev >= 4) && (ev < 10);
            if (int'(O_H_CNT) != eh) err_h++;
            if (int'(O_V_CNT) != ev) err_v++;
            if (O_HSYNC !== !(eh < 3)) err_hs++;
            if (O_VSYNC !== !(ev < 2)) err_vs++;
            if (O_DE !== de_e) err_de++;
            if (O_PIX_DATA !== (de_e ? 12'hFFF : 12'h000)) err_pix++;
            if (O_DE) begin
                de_total++;
                if (first_de_h < 0) begin first_de_h = int'(O_H_CNT); first_de_v = int'(O_V_CNT); end
                last_de_v = int'(O_V_CNT);
            end
            if (!O_HSYNC) hs_low++;
            if (!O_VSYNC) vs_low++;
        end
        check("free_hcnt_err",  32'(err_h), 0);
        check("free_vcnt_err",  32'(err_v), 0);
        check("free_hs_err",    32'(err_hs), 0);
        check("free_vs_err",    32'(err_vs), 0);
        check("free_de_err",    32'(err_de), 0);
        check("free_pix_err",   32'(err_pix), 0);
        check("free_de_total",  32'(de_total), 96);
        check("free_hs_low",    32'(hs_low), 33);
        check("free_vs_low",    32'(vs_low), 50);
        check("free_de_first_h", 32'(first_de_h), 7);
        check("free_de_first_v", 32'(first_de_v), 4);
        check("free_de_last_v",  32'(last_de_v), 9);

        // Rounding 8->4 inside DE, then zero outside DE
        wait_hv("wait_round", 7, 4);
        for (int i = 0; i < 4; i++) begin
            I_PIX_DATA = rin[i];
            tick();
            check($sformatf("round_%0d", i), 32'(O_PIX_DATA), 32'(rexp[i]));
        end
        wait_hv("wait_outde", 23, 4);
        I_PIX_DATA = 24'hFFFFFF;
        tick();
        check("round_outside_de", 32'(O_PIX_DATA), 0);

        // Resync 5 cycles after an edge at h=12,v=3 (not on wrap)
        wait_hv("wait_lock0", 11, 3);
        I_VSYNC = 1'b1;
        tick();
        I_VSYNC = 1'b0;
        for (int t = 2; t <= 6; t++) tick();
        check("resync_pre_h", 32'(O_H_CNT), 17);
        tick();
        check("resync_h", 32'(O_H_CNT), 0);
        check("resync_v", 32'(O_V_CNT), 0);
        check("resync_unlocked", 32'(O_LOCKED), 0);
        // Next edge exactly one frame after the first lands on the wrap
        for (int t = 8; t <= 275; t++) tick();
        I_VSYNC = 1'b1;
        tick();
        I_VSYNC = 1'b0;
        for (int t = 277; t <= 281; t++) tick();
        check("lock_wrap_h", 32'(O_H_CNT), 24);
        check("lock_wrap_v", 32'(O_V_CNT), 10);
        check("locked", 32'(O_LOCKED), 1);

        // Second edge 3 cycles after the first: only the later one resyncs
        wait_hv("wait_double", 11, 2);
        I_VSYNC = 1'b1;
        tick();
        I_VSYNC = 1'b0;
        tick(); tick();
        I_VSYNC = 1'b1;
        tick();
        I_VSYNC = 1'b0;
        tick(); tick(); tick();
        check("double_no_early", 32'(O_H_CNT), 18);
        tick(); tick();
        check("double_pre_h", 32'(O_H_CNT), 20);
        tick();
        check("double_h", 32'(O_H_CNT), 0);
        check("double_v", 32'(O_V_CNT), 0);
        check("double_unlocked", 32'(O_LOCKED), 0);

        // Reset while a resync is pending drops it
        wait_hv("wait_rstabort", 11, 5);
        I_VSYNC = 1'b1;
        tick();
        I_VSYNC = 1'b0;
        tick();
        I_RST = 1'b1;
        tick();
        I_RST = 1'b0;
        check("rst_mid_h", 32'(O_H_CNT), 0);
        check("rst_mid_v", 32'(O_V_CNT), 0);
        tick(); tick(); tick(); tick();
        check("rst_abort_h", 32'(O_H_CNT), 3);
        check("rst_abort_v", 32'(O_V_CNT), 0);

`ifdef VOF_TEST_PATTERN_EN
        begin
            logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                      12'hF0F, 12'hF00, 12'h00F, 12'h000};
            I_TP_EN = 1'b1;
            wait_hv("wait_tp", 6, 4);
            for (int i = 0; i < 16; i++) begin
                tick();
                check($sformatf("tp_bar_h%0d", i + 7), 32'(O_PIX_DATA), 32'(bars[i / 2]));
            end
            I_TP_EN = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
